// File: rtl/cla_addsub_pipe.sv
// cla_addsub_pipe: pipelined carry-lookahead add/sub with flags and valid/ready backpressure
module cla_addsub_pipe #(
    parameter int WIDTH  = 32,
    parameter int GROUP  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);
    localparam int SLICE = WIDTH / STAGES;
    localparam int NG    = SLICE / GROUP;

    if (WIDTH % (GROUP * STAGES) != 0) begin : g_bad_cfg
        $error("WIDTH must be divisible by GROUP*STAGES");
    end

    logic              advance;
    logic [STAGES-1:0] v_q, v_d, c_q, c_d, z_q, z_d;
    logic [WIDTH-1:0]  a_q [STAGES];
    logic [WIDTH-1:0]  a_d [STAGES];
    logic [WIDTH-1:0]  b_q [STAGES];
    logic [WIDTH-1:0]  b_d [STAGES];
    logic [WIDTH-1:0]  s_q [STAGES];
    logic [WIDTH-1:0]  s_d [STAGES];
    logic              ovf_q, ovf_d;

    // Two-level sum-of-products carries: c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]c0
    function automatic logic [WIDTH:0] lookahead(input logic [WIDTH-1:0] g, input logic [WIDTH-1:0] p,
                                                 input logic c0, input int n);
        logic [WIDTH:0] c;
        logic t, u;
        c = '0;
        c[0] = c0;
        for (int i = 0; i < n; i++) begin
            t = c0;
            for (int j = 0; j <= i; j++) t = t & p[j];
            for (int j = 0; j <= i; j++) begin
                u = g[j];
                for (int m = j + 1; m <= i; m++) u = u & p[m];
                t = t | u;
            end
            c[i + 1] = t;
        end
        return c;
    endfunction

    always_comb begin
        logic [WIDTH-1:0] ka, kb, ks, gg, gp, bg, bp;
        logic [WIDTH:0]   gc, bc;
        logic             kc, kz, kv, cmsb;
        int               p, lo;
        advance = ~v_q[STAGES-1] | out_ready;
        v_d = '0;
        c_d = '0;
        z_d = '0;
        ka = '0;
        kb = '0;
        ks = '0;
        gc = '0;
        bc = '0;
        cmsb = 1'b0;
        lo = 0;
        for (int k = 0; k < STAGES; k++) begin
            p = k == 0 ? 0 : k - 1;
            ka = k == 0 ? a : a_q[p];
            kb = k == 0 ? (sub ? ~b : b) : b_q[p];
            kc = k == 0 ? sub ^ cin : c_q[p];
            ks = k == 0 ? '0 : s_q[p];
            kz = k == 0 ? 1'b1 : z_q[p];
            kv = k == 0 ? in_valid : v_q[p];
            gg = '0;
            gp = '0;
            for (int j = 0; j < NG; j++) begin
                lo = k * SLICE + j * GROUP;
                bg = '0;
                bp = '0;
                bg[GROUP-1:0] = ka[lo +: GROUP] & kb[lo +: GROUP];
                bp[GROUP-1:0] = ka[lo +: GROUP] ^ kb[lo +: GROUP];
                bc = lookahead(bg, bp, 1'b0, GROUP);
                gg[j] = bc[GROUP];
                gp[j] = &bp[GROUP-1:0];
            end
            gc = lookahead(gg, gp, kc, NG);
            // Second pass resolves bit carries once each group's carry-in is known
            for (int j = 0; j < NG; j++) begin
                lo = k * SLICE + j * GROUP;
                bg = '0;
                bp = '0;
                bg[GROUP-1:0] = ka[lo +: GROUP] & kb[lo +: GROUP];
                bp[GROUP-1:0] = ka[lo +: GROUP] ^ kb[lo +: GROUP];
                bc = lookahead(bg, bp, gc[j], GROUP);
                ks[lo +: GROUP] = bp[GROUP-1:0] ^ bc[GROUP-1:0];
                cmsb = bc[GROUP-1];
            end
            a_d[k] = ka;
            b_d[k] = kb;
            s_d[k] = ks;
            c_d[k] = gc[NG];
            z_d[k] = kz & ~|ks[k * SLICE +: SLICE];
            v_d[k] = kv;
        end
        ovf_d = cmsb ^ c_d[STAGES-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q   <= '0;
            c_q   <= '0;
            z_q   <= '0;
            ovf_q <= 1'b0;
            a_q   <= '{default: '0};
            b_q   <= '{default: '0};
            s_q   <= '{default: '0};
        end else if (advance) begin
            v_q   <= v_d;
            c_q   <= c_d;
            z_q   <= z_d;
            ovf_q <= ovf_d;
            a_q   <= a_d;
            b_q   <= b_d;
            s_q   <= s_d;
        end
    end

    assign in_ready  = advance;
    assign out_valid = v_q[STAGES-1];
    assign sum       = s_q[STAGES-1];
    assign cout      = c_q[STAGES-1];
    assign overflow  = ovf_q;
    assign zero      = z_q[STAGES-1];
endmodule

// File: doc/cla_addsub_pipe.md
Name: cla_addsub_pipe

Overview:
Parametrised, pipelined carry-lookahead adder/subtractor. It generalises the team's 4-bit registered CLA adder to WIDTH bits, built from GROUP-bit lookahead groups. The datapath is split across STAGES register stages. It adds an add/sub mode, signed overflow and zero flags, and a valid/ready handshake with backpressure, so it can sit between ALU operand-select logic and writeback in the npc core.

Parameters:
WIDTH, 32, operand/result width in bits
GROUP, 4, bits per carry-lookahead group (G/P computed per group, group carries by lookahead)
STAGES, 2, pipeline register stages; WIDTH must be divisible by GROUP*STAGES (elaboration error otherwise)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  operand beat valid
in_ready  output  1  block can accept a beat this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry-in (add) / borrow-in (sub)
sub  input  1  0 = add, 1 = subtract
out_valid  output  1  result beat valid
out_ready  input  1  consumer accepts result
sum  output  WIDTH  result
cout  output  1  carry-out of MSB (sub: 1 = no borrow)
overflow  output  1  signed two's-complement overflow
zero  output  1  sum == 0

Behaviour:
- Reset: synchronous and active-high. When rst is sampled high, all stage valid bits clear. out_valid=0, sum=0, cout=0, overflow=0, zero=0. in_ready=1 in the cycle after reset. Reset mid-operation discards all in-flight beats; no output is produced for them.
- Arithmetic:
  - Effective B is sub ? ~b : b.
  - Effective carry-in is sub ? ~cin : cin. In sub mode this computes a - b - cin.
  - sum = a + Beff + cineff, modulo 2^WIDTH.
  - cout is the raw carry out of bit WIDTH-1.
  - overflow = carry into MSB XOR carry out of MSB.
  - zero = (sum == 0).
- Slicing:
  - SLICE = WIDTH/STAGES. Stage k (k=0..STAGES-1) computes bits [k*SLICE +: SLICE] using GROUP-bit lookahead groups.
  - Stage k takes its carry-in from stage k-1's registered carry; stage 0 uses cineff.
  - Operand bits not yet consumed and result bits already produced travel in the pipeline registers alongside the beat.
  - overflow and zero are formed in the final stage from registered values; zero accumulates per slice.
- Latency: exactly STAGES cycles from accepting handshake (in_valid & in_ready) to out_valid=1 with no stall. Throughput is 1 beat/cycle.
- Handshake:
  - advance = ~out_valid | out_ready; in_ready = advance (combinational).
  - When advance=1, every stage register loads from its predecessor; stage 0 loads valid = in_valid.
  - When advance=0, the whole pipeline holds. sum/cout/overflow/zero/out_valid stay stable while out_valid & ~out_ready.
  - Bubbles are not compressed: an empty internal stage still stalls when the output is stalled.
- Ordering: results leave in acceptance order; no beat is dropped or duplicated.
- Inputs are sampled only on an accepting handshake. a, b, cin and sub are don't-care otherwise.
- Output data fields when out_valid=0: hold the last value, with no requirement on their content.
- Simultaneous output accept and input accept in the same cycle is legal and sustains full throughput.
- The mode bit is captured per beat; mixed add/sub back-to-back beats are independent.
- STAGES=1 degenerates to a single registered CLA adder with latency 1.

Test Plan:
Config WIDTH=8, GROUP=4, STAGES=2, out_ready=1 unless stated.
1. Add a=0x7F, b=0x01, cin=0, sub=0 -> 2 cycles later: sum=0x80, cout=0, overflow=1, zero=0.
2. Add a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, overflow=0, zero=1. Add a=0x0F, b=0x00, cin=1 -> sum=0x10 (carry crosses a group and a stage boundary).
3. Sub a=0x05, b=0x07, cin=0 -> sum=0xFE, cout=0, overflow=0. Sub a=0x80, b=0x01, cin=0 -> sum=0x7F, cout=1, overflow=1. Sub a=0x05, b=0x02, cin=1 -> sum=0x02.
4. Backpressure: 4 back-to-back beats (1+1, 2+2, 3+3, 4+4), with out_ready=0 from the first out_valid for 3 cycles. Required: in_ready=0 while stalled, and sum holds 0x02 stable. After release, outputs are 0x02, 0x04, 0x06, 0x08 in order, one per cycle, and no beat is lost.
5. Reset mid-flight: accept 2 beats, assert rst for 1 cycle before they emerge -> out_valid stays 0, outputs are 0, in_ready=1 the next cycle. A new beat 0x10+0x20 yields sum=0x30 after 2 cycles.
6. Random regression vs a reference model over WIDTH=32, GROUP=4, STAGES ∈ {1, 2, 4}, with random in_valid/out_ready. Required: exact match of all flags and order, and latency STAGES when unstalled.
